wb_addr_encoder: RTL

WB_ADDR_ENCODER -- requirements
Module: wb_addr_encoder

---
 rtl/wb_addr_encoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/wb_addr_encoder.sv
// Writeback queue for evicted dirty cache lines: a 2-entry FIFO of {tag, index, data}
// drained by a simple IDLE/WRITE handshake with pmem, one line per transaction.
module wb_addr_encoder #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       evict_req,
  input  logic [s_tag-1:0]           evict_tag,
  input  logic [s_index-1:0]         evict_index,
  input  logic [8*(2**s_offset)-1:0] evict_data,
  output logic                       evict_ready,
  output logic                       pmem_write,
  output logic [31:0]                pmem_address,
  output logic [8*(2**s_offset)-1:0] pmem_wdata,
  input  logic                       pmem_resp,
  output logic                       busy
);

  localparam int data_w = 8 * (2 ** s_offset);
  localparam int depth  = 2;

  localparam logic [0:0] st_idle  = 1'b0;
  localparam logic [0:0] st_write = 1'b1;

  logic [0:0]         state_reg, state_next;
  logic [1:0]         count_reg, count_next;
  logic               wr_ptr_reg, wr_ptr_next;
  logic               rd_ptr_reg, rd_ptr_next;
  logic               push, pop;

  logic [s_tag-1:0]   tag_mem   [depth];
  logic [s_index-1:0] index_mem [depth];
  logic [data_w-1:0]  data_mem  [depth];

  logic [s_tag-1:0]   head_tag;
  logic [s_index-1:0] head_index;
  logic [data_w-1:0]  head_data;

  // Readiness comes from the registered count only, so a pop in this cycle
  // never opens a slot for a request arriving in the same cycle.
  assign evict_ready = (count_reg < 2'd2);
  assign push        = evict_req && evict_ready;
  assign pop         = (state_reg == st_write) && pmem_resp;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Two entries: a single pointer bit wraps naturally.
  assign wr_ptr_next = push ? ~wr_ptr_reg : wr_ptr_reg;
  assign rd_ptr_next = pop  ? ~rd_ptr_reg : rd_ptr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      st_idle:  if (count_reg != 2'd0) state_next = st_write;
      st_write: if (pmem_resp)         state_next = st_idle;
      default:  state_next = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= st_idle;
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        tag_mem[i]   <= '0;
        index_mem[i] <= '0;
        data_mem[i]  <= '0;
      end
    end else if (push) begin
      tag_mem[wr_ptr_reg]   <= evict_tag;
      index_mem[wr_ptr_reg] <= evict_index;
      data_mem[wr_ptr_reg]  <= evict_data;
    end
  end

  // The head only moves on pop, which also leaves WRITE, so the outputs stay
  // stable for the whole write.
  assign head_tag   = tag_mem[rd_ptr_reg];
  assign head_index = index_mem[rd_ptr_reg];
  assign head_data  = data_mem[rd_ptr_reg];

  assign pmem_write   = (state_reg == st_write);
  assign pmem_address = pmem_write ? {head_tag, head_index, {s_offset{1'b0}}} : 32'd0;
  assign pmem_wdata   = pmem_write ? head_data : '0;
  assign busy         = (count_reg != 2'd0) || (state_reg == st_write);

endmodule
